// File: rtl/elev_ctrl_pkg.sv
// Shared state encoding, default parameters and sizing helper for the SCAN elevator controller.
package elev_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } elev_state_e;

    localparam int unsigned DEF_N_FLOORS    = 4;
    localparam int unsigned DEF_DOOR_CYCLES = 8;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/elev_request_latch.sv
// Pending floor-call bitmap with set/clear arbitration (clear wins) and
// above/below reductions relative to the current floor.
module elev_request_latch
    import elev_ctrl_pkg::*;
#(
    parameter int unsigned N_FLOORS = DEF_N_FLOORS,
    parameter int unsigned FLOOR_W  = $clog2(N_FLOORS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                set_valid_i,
    input  logic [FLOOR_W-1:0]  set_floor_i,
    input  logic                clr_valid_i,
    input  logic [FLOOR_W-1:0]  clr_floor_i,
    input  logic [FLOOR_W-1:0]  cur_floor_i,
    output logic [N_FLOORS-1:0] pending_o,
    output logic                above_o,
    output logic                below_o,
    output logic                at_cur_o
);

    localparam int unsigned SPAN = 2 ** FLOOR_W;
    localparam logic [SPAN-1:0] VALID_MASK = SPAN'({N_FLOORS{1'b1}});

    logic [N_FLOORS-1:0] pending_q;
    logic [N_FLOORS-1:0] pending_d;
    logic [N_FLOORS-1:0] above_mask_c;
    logic [N_FLOORS-1:0] below_mask_c;
    logic [SPAN-1:0]     pending_ext_c;

    // Indices past the last floor are dropped; a same-edge clear beats a set.
    always_comb begin
        pending_d = pending_q;
        if (set_valid_i && VALID_MASK[set_floor_i]) begin
            pending_d[set_floor_i] = 1'b1;
        end
        if (clr_valid_i && VALID_MASK[clr_floor_i]) begin
            pending_d[clr_floor_i] = 1'b0;
        end
    end

    always_comb begin
        above_mask_c = '0;
        below_mask_c = '0;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            above_mask_c[i] = FLOOR_W'(i) > cur_floor_i;
            below_mask_c[i] = FLOOR_W'(i) < cur_floor_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_ext_c = SPAN'(pending_q);
    assign pending_o     = pending_q;
    assign above_o       = |(pending_q & above_mask_c);
    assign below_o       = |(pending_q & below_mask_c);
    assign at_cur_o      = VALID_MASK[cur_floor_i] & pending_ext_c[cur_floor_i];

endmodule

// File: rtl/elevator_scan_controller.sv
// N-floor SCAN elevator controller: FSM, direction register and door timer.
// Define ELEV_DOOR_REOPEN_EN to let door_obstruct hold the door open.
module elevator_scan_controller
    import elev_ctrl_pkg::*;
#(
    parameter int unsigned N_FLOORS    = DEF_N_FLOORS,
    parameter int unsigned FLOOR_W     = $clog2(N_FLOORS),
    parameter int unsigned DOOR_CYCLES = DEF_DOOR_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic [FLOOR_W-1:0]  req_floor,
    input  logic [FLOOR_W-1:0]  current_floor,
    input  logic                floor_valid,
    input  logic                door_obstruct,
    output logic                motor_up,
    output logic                motor_down,
    output logic                door_open,
    output logic                dir_up,
    output logic [N_FLOORS-1:0] pending
);

    localparam int unsigned        TIMER_W    = cnt_width(DOOR_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(N_FLOORS - 1);

    elev_state_e        state_q, state_d;
    logic               dir_up_q, dir_up_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               motor_up_q, motor_down_q, door_open_q;
    logic               enter_door_c;
    logic               clr_valid_c;
    logic               reopen_c;
    logic               above_c, below_c, at_cur_c, here_c;

`ifdef ELEV_DOOR_REOPEN_EN
    assign reopen_c = door_obstruct;
`else
    logic unused_obstruct;
    assign reopen_c        = 1'b0;
    assign unused_obstruct = door_obstruct;
`endif

    // Entering the door clears the served call; while open, calls for this floor are absorbed.
    assign clr_valid_c = enter_door_c || ((state_q == DOOR_OPEN) && floor_valid);

    elev_request_latch #(
        .N_FLOORS (N_FLOORS),
        .FLOOR_W  (FLOOR_W)
    ) u_latch (
        .clk         (clk),
        .reset       (reset),
        .set_valid_i (req_valid),
        .set_floor_i (req_floor),
        .clr_valid_i (clr_valid_c),
        .clr_floor_i (current_floor),
        .cur_floor_i (current_floor),
        .pending_o   (pending),
        .above_o     (above_c),
        .below_o     (below_c),
        .at_cur_o    (at_cur_c)
    );

    assign here_c = floor_valid && at_cur_c;

    always_comb begin
        state_d      = state_q;
        dir_up_d     = dir_up_q;
        timer_d      = timer_q;
        enter_door_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (here_c) begin
                    enter_door_c = 1'b1;
                end else if (dir_up_q) begin
                    if (above_c) begin
                        state_d = MOVE_UP;
                    end else if (below_c) begin
                        state_d  = MOVE_DOWN;
                        dir_up_d = 1'b0;
                    end
                end else begin
                    if (below_c) begin
                        state_d = MOVE_DOWN;
                    end else if (above_c) begin
                        state_d  = MOVE_UP;
                        dir_up_d = 1'b1;
                    end
                end
            end
            MOVE_UP: begin
                if (here_c) begin
                    enter_door_c = 1'b1;
                end else if ((floor_valid && !above_c) || (current_floor >= TOP_FLOOR)) begin
                    state_d = IDLE;
                end
            end
            MOVE_DOWN: begin
                if (here_c) begin
                    enter_door_c = 1'b1;
                end else if ((floor_valid && !below_c) || (current_floor == '0)) begin
                    state_d = IDLE;
                end
            end
            DOOR_OPEN: begin
                if (reopen_c) begin
                    timer_d = TIMER_LOAD;
                end else if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter_door_c) begin
            state_d = DOOR_OPEN;
            timer_d = TIMER_LOAD;
        end
    end

    // Outputs are registered copies of the next-state decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            dir_up_q     <= 1'b1;
            timer_q      <= '0;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            door_open_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_up_q     <= dir_up_d;
            timer_q      <= timer_d;
            motor_up_q   <= (state_d == MOVE_UP);
            motor_down_q <= (state_d == MOVE_DOWN);
            door_open_q  <= (state_d == DOOR_OPEN);
        end
    end

    assign motor_up   = motor_up_q;
    assign motor_down = motor_down_q;
    assign door_open  = door_open_q;
    assign dir_up     = dir_up_q;

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Scoreboard bench for elevator_scan_controller: directed scenarios plus random traffic
// against a behavioural SCAN model; a 6-floor instance checks out-of-range calls.
`timescale 1ns/1ps
module tb_elevator_scan_controller;

    localparam int NF = 4;
    localparam int DC = 4;
    localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_DOOR = 3;
`ifdef ELEV_DOOR_REOPEN_EN
    localparam bit REOPEN = 1'b1;
`else
    localparam bit REOPEN = 1'b0;
`endif

    typedef struct packed {
        logic          mu;
        logic          md;
        logic          door;
        logic          dir;
        logic [NF-1:0] pend;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset, req_valid, floor_valid, door_obstruct;
    logic [1:0]    req_floor, current_floor;
    logic          motor_up, motor_down, door_open, dir_up;
    logic [NF-1:0] pending;

    logic       r6, rv6, fv6, obs6, mu6, md6, do6, du6;
    logic [2:0] rf6, cf6;
    logic [5:0] pend6;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    bit m_pend[NF];
    int m_mode;
    bit m_dir;
    int m_left;

    always #5 clk = ~clk;

    elevator_scan_controller #(.N_FLOORS(NF), .DOOR_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_floor(req_floor),
        .current_floor(current_floor), .floor_valid(floor_valid), .door_obstruct(door_obstruct),
        .motor_up(motor_up), .motor_down(motor_down), .door_open(door_open),
        .dir_up(dir_up), .pending(pending)
    );

    elevator_scan_controller #(.N_FLOORS(6), .DOOR_CYCLES(DC)) dut6 (
        .clk(clk), .reset(r6), .req_valid(rv6), .req_floor(rf6),
        .current_floor(cf6), .floor_valid(fv6), .door_obstruct(obs6),
        .motor_up(mu6), .motor_down(md6), .door_open(do6),
        .dir_up(du6), .pending(pend6)
    );

    // Behavioural SCAN model: one call advances it across one clock edge.
    task automatic model_edge(input bit rst, input bit rv, input int rf,
                              input int cf, input bit fv, input bit obs);
        bit nxt[NF];
        bit above, below, here;
        int clr;
        if (rst) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_mode = M_IDLE;
            m_dir  = 1'b1;
            m_left = 0;
            return;
        end
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < NF; i++) begin
            if (m_pend[i] && i > cf) above = 1'b1;
            if (m_pend[i] && i < cf) below = 1'b1;
        end
        here = fv && (cf < NF) && m_pend[cf];
        clr  = -1;
        nxt  = m_pend;
        if (rv && rf < NF) nxt[rf] = 1'b1;
        case (m_mode)
            M_IDLE: begin
                if (here) begin
                    m_mode = M_DOOR; m_left = DC; clr = cf;
                end else if (m_dir) begin
                    if (above) m_mode = M_UP;
                    else if (below) begin m_mode = M_DOWN; m_dir = 1'b0; end
                end else begin
                    if (below) m_mode = M_DOWN;
                    else if (above) begin m_mode = M_UP; m_dir = 1'b1; end
                end
            end
            M_UP: begin
                if (here) begin m_mode = M_DOOR; m_left = DC; clr = cf; end
                else if ((fv && !above) || cf >= NF - 1) m_mode = M_IDLE;
            end
            M_DOWN: begin
                if (here) begin m_mode = M_DOOR; m_left = DC; clr = cf; end
                else if ((fv && !below) || cf == 0) m_mode = M_IDLE;
            end
            default: begin
                if (fv) clr = cf;
                if (REOPEN && obs) m_left = DC;
                else begin
                    m_left--;
                    if (m_left == 0) m_mode = M_IDLE;
                end
            end
        endcase
        if (clr >= 0) nxt[clr] = 1'b0;
        m_pend = nxt;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.mu   = (m_mode == M_UP);
        e.md   = (m_mode == M_DOWN);
        e.door = (m_mode == M_DOOR);
        e.dir  = m_dir;
        for (int i = 0; i < NF; i++) e.pend[i] = m_pend[i];
        return e;
    endfunction

    task automatic step(input bit rst, input bit rv, input int rf,
                        input int cf, input bit fv, input bit obs);
        @(negedge clk);
        reset         = rst;
        req_valid     = rv;
        req_floor     = 2'(rf);
        current_floor = 2'(cf);
        floor_valid   = fv;
        door_obstruct = obs;
        model_edge(rst, rv, rf, cf, fv, obs);
        exp_q.push_back(model_out());
    endtask

    task automatic hold(input int n, input int cf, input bit fv);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, cf, fv, 1'b0);
    endtask

    task automatic check6(input string name, input logic [5:0] got, input logic [5:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: pending got %b want %b", name, got, want);
        end
    endtask

    // Monitor: compare DUT outputs after every edge that has a queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({motor_up, motor_down, door_open, dir_up, pending} !== e || (motor_up && motor_down)) begin
                    failures++;
                    $display("FAIL outputs @%0t: got up=%b dn=%b door=%b dir=%b pend=%b want up=%b dn=%b door=%b dir=%b pend=%b",
                             $time, motor_up, motor_down, door_open, dir_up, pending,
                             e.mu, e.md, e.door, e.dir, e.pend);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_floor = '0; current_floor = '0;
        floor_valid = 1'b0; door_obstruct = 1'b0;
        r6 = 1'b1; rv6 = 1'b0; rf6 = '0; cf6 = '0; fv6 = 1'b0; obs6 = 1'b0;
        model_edge(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);

        step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);

        // Idle at 0, call 3: move up, arrive, door, idle.
        step(1'b0, 1'b1, 3, 0, 1'b1, 1'b0);
        hold(2, 0, 1'b1);
        hold(1, 1, 1'b1);
        hold(1, 2, 1'b1);
        hold(DC + 2, 3, 1'b1);

        // Moving up at 1 with calls 0 and 3: serve 3, then reverse to 0.
        step(1'b1, 1'b0, 0, 1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3, 1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 0, 1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 0, 1, 1'b1, 1'b0);
        hold(1, 2, 1'b1);
        hold(DC + 2, 3, 1'b1);
        hold(1, 2, 1'b1);
        hold(1, 1, 1'b1);
        hold(DC + 2, 0, 1'b1);

        // Door open at 2, another call for 2 is absorbed.
        step(1'b0, 1'b1, 2, 2, 1'b1, 1'b0);
        hold(2, 2, 1'b1);
        step(1'b0, 1'b1, 2, 2, 1'b1, 1'b0);
        hold(DC, 2, 1'b1);

        // Reset while moving down with pending 1010.
        step(1'b0, 1'b1, 1, 2, 1'b0, 1'b0);
        hold(1, 2, 1'b0);
        step(1'b0, 1'b1, 3, 2, 1'b0, 1'b0);
        hold(1, 2, 1'b0);
        step(1'b1, 1'b0, 0, 2, 1'b0, 1'b0);
        hold(2, 2, 1'b0);

        // Door obstructed for 5 cycles.
        step(1'b0, 1'b1, 0, 0, 1'b1, 1'b0);
        hold(1, 0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
        hold(DC + 2, 0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(99) < 2), ($urandom_range(99) < 35), $urandom_range(NF - 1),
                 $urandom_range(NF - 1), ($urandom_range(99) < 70), ($urandom_range(99) < 10));
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        // Six-floor instance: calls 6 and 7 are out of range, 5 is accepted.
        @(negedge clk); r6 = 1'b0;
        @(negedge clk); rv6 = 1'b1; rf6 = 3'd6;
        @(negedge clk); rf6 = 3'd7;
        @(negedge clk); rv6 = 1'b0;
        #6;
        check6("ignore_6_7", pend6, 6'b000000);
        @(negedge clk); rv6 = 1'b1; rf6 = 3'd5;
        @(negedge clk); rv6 = 1'b0;
        #6;
        check6("accept_5", pend6, 6'b100000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
